// File: rtl/fp_addsub_align_pipe.sv
// FP add/sub prealign/align front end: picks the larger-magnitude operand,
// aligns the smaller significand with G/R/S over a two-stage valid/ready pipe.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, a, b, operation;
//   out_valid/out_ready, op_out, sa, sb, max_ab, cexp, shift, mmax, mmin,
//   input_exc {anyNaN|anyInf, aNaN, bNaN, aInf, bInf}.
module fp_addsub_align_pipe #(
   parameter  int EXP_W  = 8,
   parameter  int MAN_W  = 23,
   localparam int MMIN_W = MAN_W + 4,
   localparam int SH_W   = $clog2(MAN_W + 4),
   localparam int W      = EXP_W + MAN_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      a,
   input  logic [W-1:0]      b,
   input  logic              operation,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              op_out,
   output logic              sa,
   output logic              sb,
   output logic              max_ab,
   output logic [EXP_W-1:0]  cexp,
   output logic [SH_W-1:0]   shift,
   output logic [MAN_W-1:0]  mmax,
   output logic [MMIN_W-1:0] mmin,
   output logic [4:0]        input_exc
);

   typedef struct packed {
      logic              op;
      logic              sa;
      logic              sb;
      logic              max_ab;
      logic [EXP_W-1:0]  cexp;
      logic [SH_W-1:0]   shift;
      logic [MAN_W-1:0]  mmax;
      logic [MMIN_W-1:0] mmin;
      logic [4:0]        exc;
   } stage_t;

   localparam logic [EXP_W-1:0] SAT_E  = EXP_W'(MAN_W + 3);
   localparam logic [SH_W-1:0]  SAT_SH = SH_W'(MAN_W + 3);

   logic   s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   stage_t s1_q, s1_d, s2_q, s2_d;
   stage_t s1_new, s2_new;
   logic   s1_adv, s2_adv;

   logic [EXP_W-1:0]  a_exp, b_exp, a_ee, b_ee, diff;
   logic [MAN_W-1:0]  a_man, b_man, min_man;
   logic              a_nan, b_nan, a_inf, b_inf, swap, min_h;
   logic [MMIN_W-1:0] sh_v;
   logic              sticky;

   // Stage 1: classify, compare, compute saturated shift.
   always_comb begin
      a_exp   = a[W-2:MAN_W];
      b_exp   = b[W-2:MAN_W];
      a_man   = a[MAN_W-1:0];
      b_man   = b[MAN_W-1:0];
      a_nan   = (&a_exp) & (|a_man);
      b_nan   = (&b_exp) & (|b_man);
      a_inf   = (&a_exp) & ~(|a_man);
      b_inf   = (&b_exp) & ~(|b_man);
      // Subnormals behave as exponent 1 with a zero hidden bit.
      a_ee    = (a_exp == '0) ? EXP_W'(1) : a_exp;
      b_ee    = (b_exp == '0) ? EXP_W'(1) : b_exp;
      swap    = a[W-2:0] < b[W-2:0];
      diff    = swap ? (b_ee - a_ee) : (a_ee - b_ee);
      min_man = swap ? a_man : b_man;
      min_h   = swap ? (|a_exp) : (|b_exp);

      s1_new        = '0;
      s1_new.op     = operation;
      s1_new.sa     = a[W-1];
      s1_new.sb     = b[W-1];
      s1_new.max_ab = swap;
      s1_new.cexp   = swap ? b_exp : a_exp;
      s1_new.shift  = (diff > SAT_E) ? SAT_SH : diff[SH_W-1:0];
      s1_new.mmax   = swap ? b_man : a_man;
      s1_new.mmin   = {min_h, min_man, 3'b000};
      s1_new.exc    = {a_nan | b_nan | a_inf | b_inf,
                       a_nan, b_nan, a_inf, b_inf};
   end

   // Stage 2: log2 barrel shifter; each level folds its dropped
   // bits into the sticky accumulator.
   always_comb begin
      sh_v   = s1_q.mmin;
      sticky = 1'b0;
      for (int k = 0; k < SH_W; k++) begin
         if (s1_q.shift[k]) begin
            sticky = sticky
                   | (|(sh_v & ~({MMIN_W{1'b1}} << (1 << k))));
            sh_v   = sh_v >> (1 << k);
         end
      end
      s2_new      = s1_q;
      s2_new.mmin = {sh_v[MMIN_W-1:1], sh_v[0] | sticky};
   end

   // Handshake: no skid buffer, in_ready is combinational from out_ready.
   always_comb begin
      s2_adv   = ~s2_v_q | out_ready;
      s1_adv   = ~s1_v_q | s2_adv;
      in_ready = s1_adv;
      s1_v_d   = s1_adv ? in_valid : s1_v_q;
      s1_d     = (s1_adv & in_valid) ? s1_new : s1_q;
      s2_v_d   = s2_adv ? s1_v_q : s2_v_q;
      s2_d     = (s2_adv & s1_v_q) ? s2_new : s2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         s1_q   <= '0;
         s2_q   <= '0;
      end else begin
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         s1_q   <= s1_d;
         s2_q   <= s2_d;
      end
   end

   assign out_valid = s2_v_q;
   assign op_out    = s2_q.op;
   assign sa        = s2_q.sa;
   assign sb        = s2_q.sb;
   assign max_ab    = s2_q.max_ab;
   assign cexp      = s2_q.cexp;
   assign shift     = s2_q.shift;
   assign mmax      = s2_q.mmax;
   assign mmin      = s2_q.mmin;
   assign input_exc = s2_q.exc;

endmodule
